barrel_coord_gen: RTL and testbench

//  Raster coordinate generator for the barrel projection path; drives the Math_X/Math_Y/

---
 rtl/barrel_coord_gen.sv | 109 ++++++++++
 tb/tb_barrel_coord_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/barrel_coord_gen.sv
// barrel_coord_gen: raster coordinate generator with per-column Q1.8 vertical scaling about CY.
// Define BARREL_COORD_CLAMP_EN to saturate math_y into 0..HEIGHT-1.
module barrel_coord_gen #(
    parameter int WIDTH  = 1080,
    parameter int HEIGHT = 960,
    parameter int CY     = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    input  logic        scale_wr_en,
    input  logic [10:0] scale_wr_addr,
    input  logic [8:0]  scale_wr_data,
    input  logic        math_ready,
    input  logic        out_ready,
    output logic [11:0] math_x,
    output logic [11:0] math_y,
    output logic        math_valid
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ROW_WAIT = 2'd1;
    localparam logic [1:0] RUN      = 2'd2;
    localparam logic [1:0] DRAIN    = 2'd3;

    logic [1:0]         state;
    logic [XW-1:0]      x, x1, x2;
    logic [YW-1:0]      y, y1;
    logic [8:0]         lut [WIDTH];
    logic [8:0]         k1;
    logic               v1, v2;
    logic               adv, last_x;
    logic signed [12:0] dy;
    logic signed [21:0] p, p2, sy;
    logic [11:0]        y_out;

    // One enable for every stage: the whole pipe freezes while the output is blocked.
    assign adv    = !math_valid || out_ready;
    assign busy   = state != IDLE;
    assign last_x = x == XW'(WIDTH - 1);

    always_comb begin
        dy = $signed(13'(y1) - 13'(CY));
        p  = $signed({{9{dy[12]}}, dy}) * $signed({13'd0, k1});
        sy = 22'(CY) + (p2 >>> 8);
`ifdef BARREL_COORD_CLAMP_EN
        y_out = (sy < 0) ? 12'd0 : (sy > $signed(22'(HEIGHT - 1))) ? 12'(HEIGHT - 1) : 12'(sy);
`else
        y_out = 12'(sy);
`endif
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && scale_wr_en && scale_wr_addr < 11'(WIDTH))
            lut[scale_wr_addr[XW-1:0]] <= scale_wr_data;
        if (adv)
            k1 <= lut[x];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            math_valid <= 1'b0;
            math_x     <= '0;
            math_y     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= ROW_WAIT;
                    x     <= '0;
                    y     <= '0;
                end
                ROW_WAIT: if (math_ready) state <= RUN;
                RUN: if (adv) begin
                    x <= last_x ? '0 : x + 1'b1;
                    if (last_x) begin
                        y     <= y + 1'b1;
                        state <= (y == YW'(HEIGHT - 1)) ? DRAIN : ROW_WAIT;
                    end
                end
                DRAIN: if (!v1 && !v2 && adv) begin
                    state      <= IDLE;
                    frame_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (adv) begin
                v1         <= state == RUN;
                x1         <= x;
                y1         <= y;
                v2         <= v1;
                x2         <= x1;
                p2         <= p;
                math_valid <= v2;
                math_x     <= 12'(x2);
                math_y     <= y_out;
            end
        end
    end
endmodule

// File: tb/tb_barrel_coord_gen.sv
// tb_barrel_coord_gen: directed table-driven bench for barrel_coord_gen (WIDTH=8, HEIGHT=4, CY=2).
module tb_barrel_coord_gen;
    localparam int W = 8, H = 4, CY = 2;
`ifdef BARREL_COORD_CLAMP_EN
    localparam logic [11:0] NEG2 = 12'd0, NEG1 = 12'd0;
`else
    localparam logic [11:0] NEG2 = 12'hFFE, NEG1 = 12'hFFF;
`endif

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, scale_wr_en = 1'b0;
    logic math_ready = 1'b1, out_ready = 1'b1;
    logic [10:0] scale_wr_addr = '0;
    logic [8:0] scale_wr_data = '0;
    logic busy, frame_done, math_valid;
    logic [11:0] math_x, math_y;
    int checks = 0, errors = 0, first_valid;
    logic [11:0] gx[$], gy[$];

    typedef struct packed {
        logic [8:0]       k;
        logic [3:0][11:0] ey;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    barrel_coord_gen #(.WIDTH(W), .HEIGHT(H), .CY(CY)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .frame_done(frame_done),
        .scale_wr_en(scale_wr_en), .scale_wr_addr(scale_wr_addr), .scale_wr_data(scale_wr_data),
        .math_ready(math_ready), .out_ready(out_ready),
        .math_x(math_x), .math_y(math_y), .math_valid(math_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [8:0] k, input logic [11:0] y0, y1, y2, y3);
        vecs[i].k = k;
        vecs[i].ey[0] = y0;
        vecs[i].ey[1] = y1;
        vecs[i].ey[2] = y2;
        vecs[i].ey[3] = y3;
    endtask

    task automatic load_k(input logic [8:0] k);
        for (int c = 0; c < W; c++) begin
            @(negedge clk);
            scale_wr_en = 1'b1;
            scale_wr_addr = 11'(c);
            scale_wr_data = k;
        end
        @(negedge clk);
        scale_wr_en = 1'b0;
    endtask

    // mode 0 plain, 1 output stall, 2 math_ready gating, 3 abort by reset at (5,2)
    task automatic run_frame(input int mode, output bit aborted);
        bit got_done = 0, win_done = 0;
        int stall = 0, win = 0;
        bit stalled = 0;
        aborted = 0;
        gx.delete();
        gy.delete();
        first_valid = -1;
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        math_ready = (mode != 2);
        for (int i = 1; i < 400; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (frame_done) begin
                check("busy_at_done", busy, 0);
                check("count_at_done", gx.size(), 32);
                got_done = 1;
                break;
            end
            if (mode == 1) begin
                if (!stalled && math_valid && math_x == 3 && math_y == 1) begin
                    stalled = 1;
                    stall = 5;
                end
                if (stall > 0) begin
                    out_ready = 1'b0;
                    check("stall_x", math_x, 3);
                    check("stall_y", math_y, 1);
                    check("stall_valid", math_valid, 1);
                    stall--;
                end else out_ready = 1'b1;
            end
            if (mode == 2) begin
                if (i <= 6) begin
                    check("wait_valid", math_valid, 0);
                    check("wait_busy", busy, 1);
                end else if (i == 7) math_ready = 1'b1;
                if (!win_done && win == 0 && math_valid && math_x == 0 && math_y == 1) begin
                    win = 12;
                    math_ready = 1'b0;
                end else if (win > 0) begin
                    win--;
                    if (win == 0) begin
                        win_done = 1;
                        check("row_gate_count", gx.size(), 16);
                        check("row_gate_valid", math_valid, 0);
                        check("row_gate_busy", busy, 1);
                        math_ready = 1'b1;
                    end
                end
            end
            if (mode == 3) begin
                scale_wr_en = (i >= 10 && i < 18);
                scale_wr_addr = 11'(i - 10);
                scale_wr_data = 9'd0;
                if (math_valid && math_x == 5 && math_y == 2) begin
                    reset = 1'b1;
                    @(negedge clk);
                    reset = 1'b0;
                    scale_wr_en = 1'b0;
                    check("abort_valid", math_valid, 0);
                    check("abort_busy", busy, 0);
                    aborted = 1;
                    return;
                end
            end
            if (math_valid && out_ready) begin
                if (first_valid < 0) first_valid = i;
                gx.push_back(math_x);
                gy.push_back(math_y);
            end
        end
        check("frame_done_seen", got_done, 1);
        @(negedge clk);
        check("done_pulse_width", frame_done, 0);
    endtask

    task automatic verify(input int v, input string tag);
        check({tag, "_count"}, gx.size(), 32);
        for (int n = 0; n < gx.size() && n < 32; n++) begin
            check({tag, "_x"}, gx[n], 12'(n % W));
            check({tag, "_y"}, gy[n], vecs[v].ey[n / W]);
        end
    endtask

    initial begin
        bit ab;
        set_vec(0, 9'd256, 12'd0, 12'd1, 12'd2, 12'd3);
        set_vec(1, 9'd128, 12'd1, 12'd1, 12'd2, 12'd2);
        set_vec(2, 9'd511, NEG2, 12'd0, 12'd2, 12'd3);
        set_vec(3, 9'd384, NEG1, 12'd0, 12'd2, 12'd3);
        set_vec(4, 9'd0, 12'd2, 12'd2, 12'd2, 12'd2);

        repeat (3) @(negedge clk);
        check("rst_valid", math_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_x", math_x, 0);
        check("rst_y", math_y, 0);
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("reset_beats_start", busy, 0);

        for (int v = 0; v < 5; v++) begin
            load_k(vecs[v].k);
            run_frame(0, ab);
            verify(v, $sformatf("vec%0d", v));
            if (v == 0) check("first_valid_latency", first_valid, 5);
        end

        load_k(9'd256);
        run_frame(1, ab);
        verify(0, "stall");
        run_frame(2, ab);
        verify(0, "gate");

        @(negedge clk);
        scale_wr_en = 1'b1;
        scale_wr_addr = 11'd8;
        scale_wr_data = 9'd0;
        @(negedge clk);
        scale_wr_en = 1'b0;
        run_frame(3, ab);
        check("aborted", ab, 1);
        run_frame(0, ab);
        verify(0, "after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
